host_rom_loader: RTL
====================

# host_rom_loader

Boot-time ROM loader between the control module's host boot-data channel and the SRAM write port of the CPC memory manager. It accepts 32-bit words over a four-phase req/ack handshake and unpacks each into four bytes. Each byte is written into SRAM with a setup/strobe/hold sequence at consecutive addresses starting at `ROM_LOCATION`. It raises `rom_initialised` once `ROM_BYTES` bytes have been written; while `rom_initialised` is 0, the memory manager routes its write outputs to the SRAM.

## Interface
- `ROM_LOCATION`, 19'h5c000: SRAM byte address of the first ROM byte.
- `ROM_BYTES`, 20'h10000: total bytes to load, range 1..2^19.
- `WR_CYCLES`, 2: strobe width in clocks, minimum 1.
- `CONFIG_ON_STARTUP`, 1:
  - 1: load after reset.
  - 0: `rom_initialised` = 1 after reset until a `host_reset` pulse.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `host_reset` in 1: synchronous restart of the load, active-high, single cycle or level.
- `host_bootdata` in 32: data word, valid while `host_bootdata_req` = 1.
- `host_bootdata_req` in 1: host request.
- `host_bootdata_ack` out 1: word-accepted acknowledge.
- `romwrite_data` out 8: byte to SRAM.
- `romwrite_addr` out 19: SRAM byte address.
- `romwrite_wr` out 1: write strobe, active-high; the SRAM sees it as `we_n` = !`romwrite_wr`.
- `rom_initialised` out 1: load complete.

## Operation
- States: WAIT_REQ, SETUP, STROBE, HOLD, DONE.
- Reset (`reset_n` = 0):
  - `host_bootdata_ack` = 0, `romwrite_wr` = 0, `romwrite_data` = 8'h00, `romwrite_addr` = `ROM_LOCATION`, byte count = 0.
  - If `CONFIG_ON_STARTUP` = 1: state = WAIT_REQ, `rom_initialised` = 0.
  - Otherwise: state = DONE, `rom_initialised` = 1.
- WAIT_REQ, with req = 1 and ack = 0:
  - Latch `host_bootdata` into the word register and set ack = 1.
  - Set byte index = 0 and go to SETUP.
- Ack handling, in every state: once ack = 1, it drops to 0 in the first cycle req is sampled 0.
- A new word is accepted only in WAIT_REQ with ack = 0. Req held high after ack therefore never double-loads.
- Byte order is little-endian: byte 0 = bits [7:0], byte 3 = bits [31:24].
- SETUP (1 cycle):
  - `romwrite_data` = selected byte; `romwrite_addr` holds its current value; wr = 0.
- STROBE (`WR_CYCLES` cycles):
  - wr = 1; data and address are stable throughout.
- HOLD (1 cycle):
  - wr = 0; data and address are still stable.
  - Then: address +1 modulo 2^19 and count +1.
- After HOLD:
  - If count = `ROM_BYTES`: go to DONE and set `rom_initialised` = 1.
  - Else if byte index < 3: increment the index and go to SETUP.
  - Else go to WAIT_REQ.
- Partial final word: bytes beyond `ROM_BYTES` are discarded.
- DONE:
  - Words arriving are still acknowledged (same four-phase rule) and discarded; the host never stalls.
  - wr stays 0.
- `host_reset` = 1, in any state, has priority over all other actions:
  - Next state WAIT_REQ; `rom_initialised` = 0; address = `ROM_LOCATION`; count = 0; wr = 0.
  - Ack is unaffected; it still follows the req-low rule.
  - A byte sequence in progress is abandoned: wr falls immediately, and that byte is not counted.
- Address wrap: `ROM_LOCATION` + count above 19'h7FFFF wraps to 0. No error is raised.

## Timing
- Req sampled high in WAIT_REQ at edge N:
  - Ack = 1 and state = SETUP after edge N.
  - First wr = 1 after edge N+1.
- Cost per byte: `WR_CYCLES` + 2 clocks.
- Cost per word: 4·(`WR_CYCLES` + 2) clocks, plus 1 clock of word acceptance.
- Address setup before wr rises ≥ 1 clock; hold after wr falls ≥ 1 clock. All outputs are registered.
- `rom_initialised` rises on the edge that leaves the final HOLD.
- Req deasserted by the host at edge M → ack = 0 after edge M+1.
- `reset_n` assertion clears outputs asynchronously. Deassertion needs no synchronisation beyond the team's reset synchroniser.

## Test plan
- Basic word load (`ROM_BYTES` = 4, `WR_CYCLES` = 2), one word 32'hDDCCBBAA:
  - Four strobes of 2 cycles each, at addresses 5c000..5c003, with data AA, BB, CC, DD.
  - `rom_initialised` rises after cycle 1 + 16.
- Handshake with req held high for 30 cycles:
  - Exactly one word is accepted; ack = 1 until the cycle after req falls.
  - The second word is accepted only after req 0→1.
- Partial final word (`ROM_BYTES` = 6, two words):
  - Six writes; the last two bytes of the second word are not written.
  - Ack is given for any third word, with no wr activity.
- Restart with `host_reset` during STROBE of byte 2:
  - wr = 0 the next cycle.
  - The reload restarts at 5c000 and `rom_initialised` stays 0 until the full count is reached.
- Address wrap (`ROM_LOCATION` = 19'h7FFFE, `ROM_BYTES` = 4):
  - Addresses 7FFFE, 7FFFF, 00000, 00001.
- `CONFIG_ON_STARTUP` = 0:
  - `rom_initialised` = 1 out of reset; req words are acknowledged with no writes.
  - After a `host_reset` pulse, loading proceeds normally.
- Async reset mid-word:
  - wr, ack = 0 immediately; address = `ROM_LOCATION`.

Source files
------------

// File: rtl/host_rom_loader.sv
// Boot ROM loader: takes 32-bit words over a four-phase req/ack handshake and
// writes them byte-wise, little-endian, into SRAM with setup/strobe/hold timing.
module host_rom_loader #(
  parameter logic [18:0] ROM_LOCATION      = 19'h5c000,
  parameter logic [19:0] ROM_BYTES         = 20'h10000,
  parameter int          WR_CYCLES         = 2,
  parameter bit          CONFIG_ON_STARTUP = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_reset,
  input  logic [31:0] host_bootdata,
  input  logic        host_bootdata_req,
  output logic        host_bootdata_ack,
  output logic [7:0]  romwrite_data,
  output logic [18:0] romwrite_addr,
  output logic        romwrite_wr,
  output logic        rom_initialised
);

  typedef enum logic [2:0] {WAIT_REQ, SETUP, STROBE, HOLD, DONE} state_t;

  localparam int WCW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  state_t           r_state, w_state;
  logic [31:0]      r_word, w_word;
  logic [1:0]       r_idx, w_idx;
  logic [19:0]      r_cnt, w_cnt;
  logic [18:0]      r_addr, w_addr;
  logic [7:0]       r_data, w_data;
  logic             r_wr, w_wr;
  logic             r_ack, w_ack;
  logic             r_init, w_init;
  logic [WCW-1:0]   r_wcnt, w_wcnt;

  logic [1:0]       w_nidx;
  logic [7:0]       w_nbyte;
  logic [19:0]      w_cnt_inc;

  assign w_nidx    = r_idx + 2'd1;
  assign w_nbyte   = 8'(r_word >> {w_nidx, 3'b000});
  assign w_cnt_inc = r_cnt + 20'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CONFIG_ON_STARTUP ? WAIT_REQ : DONE;
      r_init  <= !CONFIG_ON_STARTUP;
      r_word  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_addr  <= ROM_LOCATION;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_ack   <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_init  <= w_init;
      r_word  <= w_word;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_wr    <= w_wr;
      r_ack   <= w_ack;
      r_wcnt  <= w_wcnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_init  = r_init;
    w_word  = r_word;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_data  = r_data;
    w_wr    = r_wr;
    w_ack   = r_ack;
    w_wcnt  = r_wcnt;
    // Ack release runs independently of the state, including during restart.
    if (r_ack && !host_bootdata_req) w_ack = 1'b0;
    if (host_reset) begin
      w_state = WAIT_REQ;
      w_init  = 1'b0;
      w_addr  = ROM_LOCATION;
      w_cnt   = '0;
      w_wr    = 1'b0;
    end else begin
      case (r_state)
        WAIT_REQ: if (host_bootdata_req && !r_ack) begin
          w_word  = host_bootdata;
          w_ack   = 1'b1;
          w_idx   = 2'd0;
          w_data  = host_bootdata[7:0];
          w_state = SETUP;
        end
        SETUP: begin
          w_wr    = 1'b1;
          w_wcnt  = '0;
          w_state = STROBE;
        end
        STROBE: if (r_wcnt == WCW'(WR_CYCLES - 1)) begin
          w_wr    = 1'b0;
          w_state = HOLD;
        end else begin
          w_wcnt  = r_wcnt + WCW'(1);
        end
        HOLD: begin
          w_addr = r_addr + 19'd1;
          w_cnt  = w_cnt_inc;
          if (w_cnt_inc == ROM_BYTES) begin
            w_state = DONE;
            w_init  = 1'b1;
          end else if (r_idx != 2'd3) begin
            w_idx   = w_nidx;
            w_data  = w_nbyte;
            w_state = SETUP;
          end else begin
            w_state = WAIT_REQ;
          end
        end
        DONE: if (host_bootdata_req && !r_ack) w_ack = 1'b1;
        default: w_state = WAIT_REQ;
      endcase
    end
  end

  assign host_bootdata_ack = r_ack;
  assign romwrite_data     = r_data;
  assign romwrite_addr     = r_addr;
  assign romwrite_wr       = r_wr;
  assign rom_initialised   = r_init;

endmodule
